// File: rtl/sprite_raster_ctrl_pkg.sv
// Shared definitions for the sprite raster controller: object word layout and size helper.
// Object word is {x[9:0], y[9:0], sz[3:0]}; the square side is SZ_UNIT*(sz+1) pixels.
package sprite_raster_ctrl_pkg;

   localparam int unsigned OBJ_W   = 24;
   localparam int unsigned X_LSB   = 14;
   localparam int unsigned Y_LSB   = 4;
   localparam int unsigned SZ_LSB  = 0;
   localparam int unsigned SZ_UNIT = 8;
   localparam int unsigned FLD_W   = 10;
   localparam int unsigned SPAN_W  = 11;

   // Widen before the +1 so sz = 15 yields 128 rather than wrapping to 0.
   function automatic logic [SPAN_W-1:0] obj_span(input logic [3:0] sz);
      return (SPAN_W'(sz) + SPAN_W'(1)) * SPAN_W'(SZ_UNIT);
   endfunction

endpackage

// File: rtl/sprite_raster_ctrl_obj_hit.sv
// Rectangle hit test for one object channel against a raster coordinate.
// Compared one bit wider than the widest operand so x + span never wraps.
module sprite_raster_ctrl_obj_hit
   import sprite_raster_ctrl_pkg::*;
#(
   parameter int unsigned CW = 10
) (
   input  logic [CW-1:0]    px,
   input  logic [CW-1:0]    py,
   input  logic [OBJ_W-1:0] obj,
   input  logic             en,
   output logic             hit
);

   localparam int unsigned W = ((CW > FLD_W) ? CW : FLD_W) + 1;

   logic [W-1:0] ox;
   logic [W-1:0] oy;
   logic [W-1:0] span;
   logic [W-1:0] pxw;
   logic [W-1:0] pyw;

   always_comb begin
      ox   = W'(obj[X_LSB +: FLD_W]);
      oy   = W'(obj[Y_LSB +: FLD_W]);
      span = W'(obj_span(obj[SZ_LSB +: 4]));
      pxw  = W'(px);
      pyw  = W'(py);
      hit  = en && (pxw >= ox) && (pxw < ox + span) && (pyw >= oy) && (pyw < oy + span);
   end

endmodule

// File: rtl/sprite_raster_ctrl.sv
// Raster scanner compositing N_OBJ double-buffered rectangles over a background colour,
// emitting one pixel per valid/ready transfer through a two-stage pipeline.
module sprite_raster_ctrl
   import sprite_raster_ctrl_pkg::*;
#(
   parameter int unsigned N_OBJ = 4,
   parameter int unsigned H_ACT = 640,
   parameter int unsigned V_ACT = 480,
   parameter int unsigned CW    = 10
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   run,
   input  logic [N_OBJ*OBJ_W-1:0] obj_data,
   input  logic [N_OBJ*24-1:0]    obj_color,
   input  logic [N_OBJ-1:0]       obj_en,
   input  logic                   obj_load,
   input  logic [23:0]            bg_color,
   input  logic                   pix_ready,
   output logic                   pix_valid,
   output logic [15:0]            pixel_x,
   output logic [15:0]            pixel_y,
   output logic [23:0]            color,
   output logic                   sof,
   output logic                   eol,
   output logic                   busy
);

   localparam logic [CW-1:0] H_LAST = CW'(H_ACT - 1);
   localparam logic [CW-1:0] V_LAST = CW'(V_ACT - 1);

   logic [CW-1:0]          hx_q;
   logic [CW-1:0]          vy_q;
   logic                   load_pend_q;
   logic [N_OBJ*OBJ_W-1:0] sh_data_q;
   logic [N_OBJ*24-1:0]    sh_color_q;
   logic [N_OBJ-1:0]       sh_en_q;
   logic [23:0]            sh_bg_q;

   logic                   s1_valid_q;
   logic                   s1_sof_q;
   logic                   s1_eol_q;
   logic [CW-1:0]          s1_x_q;
   logic [CW-1:0]          s1_y_q;

   logic                   adv;
   logic                   at_origin;
   logic                   issue;
   logic                   frame_start;
   logic [N_OBJ-1:0]       hit;
   logic [23:0]            sel_color;

   assign adv         = !pix_valid || pix_ready;
   assign at_origin   = (hx_q == '0) && (vy_q == '0);
   // Mid-frame the counter always runs; at the frame boundary it waits for run.
   assign issue       = adv && (run || !at_origin);
   assign frame_start = issue && at_origin;
   assign busy        = !at_origin || s1_valid_q || pix_valid;

   for (genvar g = 0; g < N_OBJ; g++) begin : g_hit
      sprite_raster_ctrl_obj_hit #(
         .CW (CW)
      ) u_hit (
         .px  (s1_x_q),
         .py  (s1_y_q),
         .obj (sh_data_q[g*OBJ_W +: OBJ_W]),
         .en  (sh_en_q[g]),
         .hit (hit[g])
      );
   end

   // Walk from the lowest priority upward so channel 0 wins by being assigned last.
   always_comb begin
      sel_color = sh_bg_q;
      for (int i = int'(N_OBJ) - 1; i >= 0; i--) begin
         if (hit[i]) begin
            sel_color = sh_color_q[i*24 +: 24];
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         hx_q        <= '0;
         vy_q        <= '0;
         load_pend_q <= 1'b0;
         sh_data_q   <= '0;
         sh_color_q  <= '0;
         sh_en_q     <= '0;
         sh_bg_q     <= '0;
         s1_valid_q  <= 1'b0;
         s1_sof_q    <= 1'b0;
         s1_eol_q    <= 1'b0;
         s1_x_q      <= '0;
         s1_y_q      <= '0;
         pix_valid   <= 1'b0;
         pixel_x     <= '0;
         pixel_y     <= '0;
         color       <= '0;
         sof         <= 1'b0;
         eol         <= 1'b0;
      end else begin
         // The shadow set only ever changes together with issuing pixel (0,0).
         if (frame_start && (load_pend_q || obj_load)) begin
            sh_data_q   <= obj_data;
            sh_color_q  <= obj_color;
            sh_en_q     <= obj_en;
            sh_bg_q     <= bg_color;
            load_pend_q <= 1'b0;
         end else if (obj_load) begin
            load_pend_q <= 1'b1;
         end

         if (issue) begin
            if (hx_q == H_LAST) begin
               hx_q <= '0;
               vy_q <= (vy_q == V_LAST) ? '0 : vy_q + 1'b1;
            end else begin
               hx_q <= hx_q + 1'b1;
            end
         end

         if (adv) begin
            s1_valid_q <= issue;
            s1_sof_q   <= issue && at_origin;
            s1_eol_q   <= issue && (hx_q == H_LAST);
            s1_x_q     <= hx_q;
            s1_y_q     <= vy_q;
            pix_valid  <= s1_valid_q;
            pixel_x    <= 16'(s1_x_q);
            pixel_y    <= 16'(s1_y_q);
            color      <= sel_color;
            sof        <= s1_sof_q;
            eol        <= s1_eol_q;
         end
      end
   end

endmodule

// File: tb/tb_sprite_raster_ctrl.sv
// Scoreboard bench for sprite_raster_ctrl on a reduced 32x24 raster: the driver queues expected
// pixels per frame, a negedge monitor pops and compares each accepted pixel.
module tb_sprite_raster_ctrl;

   localparam int unsigned N_OBJ = 4;
   localparam int unsigned H_ACT = 32;
   localparam int unsigned V_ACT = 24;
   localparam int unsigned CW    = 10;
   localparam int          FRAME = H_ACT * V_ACT;

   typedef struct packed {
      logic [95:0] d;
      logic [95:0] c;
      logic [3:0]  en;
      logic [23:0] bg;
   } cfg_t;

   typedef struct packed {
      logic [15:0] x;
      logic [15:0] y;
      logic [23:0] col;
      logic        sof;
      logic        eol;
   } pix_t;

   typedef struct {
      int          fr;
      int          x;
      int          y;
      logic [23:0] col;
   } spot_t;

   logic        clk = 1'b0;
   logic        rst;
   logic        run;
   logic [95:0] obj_data;
   logic [95:0] obj_color;
   logic [3:0]  obj_en;
   logic        obj_load;
   logic [23:0] bg_color;
   logic        pix_ready = 1'b1;
   logic        pix_valid;
   logic [15:0] pixel_x;
   logic [15:0] pixel_y;
   logic [23:0] color;
   logic        sof;
   logic        eol;
   logic        busy;

   always #5 clk = ~clk;

   sprite_raster_ctrl #(
      .N_OBJ (N_OBJ),
      .H_ACT (H_ACT),
      .V_ACT (V_ACT),
      .CW    (CW)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .run       (run),
      .obj_data  (obj_data),
      .obj_color (obj_color),
      .obj_en    (obj_en),
      .obj_load  (obj_load),
      .bg_color  (bg_color),
      .pix_ready (pix_ready),
      .pix_valid (pix_valid),
      .pixel_x   (pixel_x),
      .pixel_y   (pixel_y),
      .color     (color),
      .sof       (sof),
      .eol       (eol),
      .busy      (busy)
   );

   int    n_checks = 0;
   int    n_pass   = 0;
   pix_t  exp_q[$];
   spot_t spots[$];
   int    spot_hits = 0;
   bit    mon_en    = 1'b0;
   bit    rnd_ready = 1'b0;
   int    mon_count = 0;
   int    mon_frame = -1;

   function automatic void chk(string name, logic [63:0] act, logic [63:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %h, expected %h", name, act, exp);
   endfunction

   function automatic void fail_now(string name);
      n_checks++;
      $display("FAIL %s: got no event, expected one within the cycle budget", name);
   endfunction

   function automatic logic [23:0] obj(int x, int y, int sz);
      return {10'(x), 10'(y), 4'(sz)};
   endfunction

   // Behavioural reference: first enabled rectangle (by index) containing the pixel wins.
   function automatic logic [23:0] model_color(int px, int py, cfg_t c);
      for (int i = 0; i < 4; i++) begin
         int ox;
         int oy;
         int span;
         ox   = int'(c.d[24*i+14 +: 10]);
         oy   = int'(c.d[24*i+4 +: 10]);
         span = 8 * (int'(c.d[24*i +: 4]) + 1);
         if (c.en[i] && px >= ox && px < ox + span && py >= oy && py < oy + span)
            return c.c[24*i +: 24];
      end
      return c.bg;
   endfunction

   task automatic push_frame(input cfg_t c);
      pix_t p;
      for (int y = 0; y < int'(V_ACT); y++) begin
         for (int x = 0; x < int'(H_ACT); x++) begin
            p.x   = 16'(x);
            p.y   = 16'(y);
            p.col = model_color(x, y, c);
            p.sof = (x == 0 && y == 0);
            p.eol = (x == int'(H_ACT) - 1);
            exp_q.push_back(p);
         end
      end
   endtask

   task automatic add_spot(input int fr, input int x, input int y, input logic [23:0] col);
      spot_t s;
      s.fr = fr; s.x = x; s.y = y; s.col = col;
      spots.push_back(s);
   endtask

   // Ready is changed at the negedge, then everything the next posedge will see is sampled.
   always @(negedge clk) begin
      pix_t cur;
      pix_t exp;
      pix_t held;
      bit   have_hold;
      pix_ready = rnd_ready ? 1'($urandom_range(1, 0)) : 1'b1;
      #1;
      if (!mon_en) begin
         have_hold = 1'b0;
      end else begin
         cur = {pixel_x, pixel_y, color, sof, eol};
         if (have_hold) begin
            chk("hold_valid", 64'(pix_valid), 64'(1));
            if (pix_valid) chk("hold_data", 64'(cur), 64'(held));
         end
         have_hold = 1'b0;
         if (pix_valid && pix_ready) begin
            if (exp_q.size() == 0) begin
               fail_now("unexpected_pixel");
            end else begin
               exp = exp_q.pop_front();
               chk($sformatf("pixel(%0d,%0d)", exp.x, exp.y), 64'(cur), 64'(exp));
               if (exp.sof) mon_frame++;
               foreach (spots[i]) begin
                  if (spots[i].fr == mon_frame && spots[i].x == int'(exp.x) &&
                      spots[i].y == int'(exp.y)) begin
                     spot_hits++;
                     chk($sformatf("spot f%0d(%0d,%0d)", mon_frame, exp.x, exp.y),
                         64'(cur.col), 64'(spots[i].col));
                  end
               end
               mon_count++;
            end
         end else if (pix_valid) begin
            held      = cur;
            have_hold = 1'b1;
         end
      end
   end

   task automatic wait_pix(input int n);
      int k = 0;
      while (mon_count < n && k < 20000) begin
         @(negedge clk);
         #2;
         k++;
      end
      if (mon_count < n) fail_now($sformatf("wait_pix_%0d", n));
   endtask

   task automatic apply_cfg(input cfg_t c);
      obj_data  = c.d;
      obj_color = c.c;
      obj_en    = c.en;
      bg_color  = c.bg;
   endtask

   task automatic pulse_load();
      obj_load = 1'b1;
      @(negedge clk);
      obj_load = 1'b0;
   endtask

   task automatic check_all_zero(input string tag);
      chk({tag, "_valid"}, 64'(pix_valid), 64'(0));
      chk({tag, "_x"}, 64'(pixel_x), 64'(0));
      chk({tag, "_y"}, 64'(pixel_y), 64'(0));
      chk({tag, "_color"}, 64'(color), 64'(0));
      chk({tag, "_sof"}, 64'(sof), 64'(0));
      chk({tag, "_eol"}, 64'(eol), 64'(0));
      chk({tag, "_busy"}, 64'(busy), 64'(0));
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: got timeout, expected completion");
      $display("%0d/%0d checks passed", n_pass, n_checks + 1);
      $finish;
   end

   initial begin
      cfg_t cz, cdum, c1, c2, c3, c4, cjunk;
      int   seen;
      int   k;

      cz = '0;
      cdum = '0;
      cdum.d[23:0] = obj(0, 0, 15); cdum.c[23:0] = 24'h00FF00; cdum.en = 4'b0001;
      cdum.bg = 24'hAAAAAA;
      c1 = '0;
      c1.d[23:0] = obj(10, 5, 1); c1.c[23:0] = 24'hFF0000; c1.en = 4'b0001; c1.bg = 24'h101010;
      c2 = '0;
      c2.d = {obj(28, 20, 2), obj(18, 8, 0), obj(0, 0, 3), obj(20, 10, 0)};
      c2.c = {24'h00FF00, 24'h0000FF, 24'hFFFF00, 24'hFF0000};
      c2.en = 4'b1101; c2.bg = 24'h101010;
      c3 = c2;
      c3.en = 4'b1100;
      c4 = '0;
      c4.d = {obj(12, 14, 15), obj(18, 8, 0), obj(1020, 0, 15), obj(4, 3, 0)};
      c4.c = {24'hFFFFFF, 24'h0000FF, 24'hFFFF00, 24'hFF0000};
      c4.en = 4'b1011; c4.bg = 24'h202020;
      cjunk = c4;
      cjunk.d[23:0] = obj(0, 0, 15); cjunk.en = 4'b1111; cjunk.bg = 24'h000000;

      add_spot(0, 0, 0, 24'h000000);   add_spot(0, 31, 23, 24'h000000);
      add_spot(1, 9, 5, 24'h101010);   add_spot(1, 26, 5, 24'h101010);
      add_spot(1, 10, 21, 24'h101010); add_spot(1, 10, 5, 24'hFF0000);
      add_spot(1, 25, 20, 24'hFF0000);
      add_spot(2, 21, 11, 24'hFF0000); add_spot(2, 19, 9, 24'h0000FF);
      add_spot(2, 31, 23, 24'h00FF00); add_spot(2, 27, 20, 24'h101010);
      add_spot(2, 0, 0, 24'h101010);
      add_spot(3, 21, 11, 24'h0000FF); add_spot(3, 5, 4, 24'h101010);
      add_spot(3, 28, 21, 24'h00FF00);
      add_spot(4, 4, 3, 24'hFF0000);   add_spot(4, 11, 10, 24'hFF0000);
      add_spot(4, 12, 10, 24'h202020); add_spot(4, 0, 0, 24'h202020);
      add_spot(4, 12, 14, 24'hFFFFFF); add_spot(4, 31, 23, 24'hFFFFFF);
      add_spot(4, 11, 14, 24'h202020); add_spot(4, 21, 11, 24'h202020);
      add_spot(4, 28, 21, 24'hFFFFFF);
      add_spot(5, 4, 3, 24'hFF0000);   add_spot(5, 0, 0, 24'h202020);
      add_spot(5, 31, 23, 24'hFFFFFF);
      add_spot(6, 4, 3, 24'hFF0000);

      rst = 1'b1; run = 1'b0; obj_load = 1'b0;
      apply_cfg(cz);
      bg_color = 24'h123456;
      repeat (3) @(negedge clk);
      rst = 1'b0;
      #1;
      check_all_zero("reset");

      // Frame 0: no load ever issued, so the reset shadow (all disabled, bg 0) is used.
      push_frame(cz);
      mon_en = 1'b1;
      run    = 1'b1;
      @(posedge clk); #1;
      chk("lat_cycle1_valid", 64'(pix_valid), 64'(0));
      chk("lat_busy", 64'(busy), 64'(1));
      @(posedge clk); #1;
      chk("lat_cycle2_valid", 64'(pix_valid), 64'(1));
      chk("lat_sof", 64'(sof), 64'(1));

      wait_pix(200);
      apply_cfg(cdum); pulse_load();
      apply_cfg(c1);   pulse_load();
      push_frame(c1);

      wait_pix(FRAME + 200);
      apply_cfg(c2); pulse_load();
      push_frame(c2);

      wait_pix(2 * FRAME + 200);
      apply_cfg(c3); pulse_load();
      push_frame(c3);
      rnd_ready = 1'b1;

      wait_pix(3 * FRAME + 12 * int'(H_ACT) + 16 + 1);
      apply_cfg(c4); pulse_load();
      push_frame(c4);

      // Input change without a load must not reach the next frame.
      wait_pix(4 * FRAME + 100);
      apply_cfg(cjunk);
      push_frame(c4);
      rnd_ready = 1'b0;

      wait_pix(5 * FRAME + 5 * int'(H_ACT) + 10 + 1);
      run = 1'b0;
      k = 0;
      while (busy && k < 5000) begin
         @(negedge clk); #2;
         k++;
      end
      if (busy) fail_now("busy_drop");
      chk("stop_pixel_count", 64'(mon_count), 64'(6 * FRAME));
      chk("stop_queue_drained", 64'(exp_q.size()), 64'(0));
      seen = 0;
      repeat (20) begin
         @(negedge clk); #2;
         if (pix_valid || busy) seen++;
      end
      chk("stop_idle", 64'(seen), 64'(0));

      push_frame(c4);
      run = 1'b1;
      wait_pix(6 * FRAME + 8 * int'(H_ACT) + 15 + 1);
      mon_en = 1'b0;
      rst    = 1'b1;
      @(posedge clk); #1;
      check_all_zero("midrst");
      exp_q.delete();
      @(negedge clk);
      rst = 1'b0;
      run = 1'b0;
      seen = 0;
      repeat (10) begin
         @(negedge clk); #2;
         if (pix_valid) seen++;
      end
      chk("post_rst_no_valid", 64'(seen), 64'(0));
      chk("spots_hit", 64'(spot_hits), 64'(spots.size()));

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
